// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with an integrated transmit FIFO.
// Runtime-selectable 5..8 data bits, 1 or 2 stop bits and a programmable
// baud divisor; queued words are sent back-to-back with no idle gap.
// Optional build macro UART_TX_PARITY_EN adds cfg_parity_i and a PARITY state.
module uart_tx_fifo #(
   parameter int FIFO_DEPTH = 8,
   parameter int DIV_W      = 16
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          cfg_en_i,
   input  logic [1:0]                    cfg_bits_i,
   input  logic                          cfg_stop_i,
   input  logic [DIV_W-1:0]              cfg_div_i,
`ifdef UART_TX_PARITY_EN
   input  logic [1:0]                    cfg_parity_i,
`endif
   input  logic [7:0]                    tx_data_i,
   input  logic                          tx_valid_i,
   output logic                          tx_ready_o,
   output logic                          tx_o,
   output logic                          busy_o,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

   // FIFO storage and bookkeeping
   logic [7:0]       mem [FIFO_DEPTH];
   logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
   logic [LW-1:0]    level_reg, level_next;
   logic             out_en_reg;
   logic             full, empty, push, pop;

   // Frame engine state
   state_t           state_reg, state_next;
   logic             busy_reg, busy_next;
   logic             tx_reg, tx_next;
   logic [7:0]       shift_reg, shift_next;
   logic [2:0]       nbits_reg, nbits_next;     // data bits minus one
   logic             two_stop_reg, two_stop_next;
   logic [DIV_W-1:0] div_reg, div_next;
   logic [DIV_W-1:0] baud_reg, baud_next;
   logic [2:0]       bit_cnt_reg, bit_cnt_next;
   logic             stop_cnt_reg, stop_cnt_next;
   logic             bit_end, start_frame;
`ifdef UART_TX_PARITY_EN
   logic [1:0]       par_mode_reg, par_mode_next;
   logic             par_acc_reg, par_acc_next;
   logic             par_bit;
`endif

   assign full         = (level_reg == LW'(FIFO_DEPTH));
   assign empty        = (level_reg == '0);
   // Ready comes only from registered state and cfg_en_i, never from tx_valid_i;
   // a same-cycle pop does not open a slot because full is the pre-edge level.
   assign tx_ready_o   = out_en_reg && cfg_en_i && !full;
   assign push         = tx_valid_i && tx_ready_o;
   assign tx_o         = tx_reg;
   assign busy_o       = busy_reg;
   assign fifo_level_o = level_reg;
   assign bit_end      = (baud_reg == div_reg - 1'b1);

   // FIFO write port (storage carries no reset so it can map onto RAM)
   always_ff @(posedge clock) begin
      if (push) begin
         mem[wr_ptr_reg] <= tx_data_i;
      end
   end

   // FIFO level update from push/pop
   always_comb begin
      level_next = level_reg;
      case ({push, pop})
         2'b10:   level_next = level_reg + 1'b1;
         2'b01:   level_next = level_reg - 1'b1;
         default: level_next = level_reg;
      endcase
   end

   // FIFO pointers, level and the post-reset ready qualifier
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
         out_en_reg <= 1'b0;
      end else begin
         out_en_reg <= 1'b1;
         level_reg  <= level_next;
         if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
   end

   // Next-state and datapath logic for the frame engine
   always_comb begin
      state_next    = state_reg;
      tx_next       = tx_reg;
      shift_next    = shift_reg;
      nbits_next    = nbits_reg;
      two_stop_next = two_stop_reg;
      div_next      = div_reg;
      bit_cnt_next  = bit_cnt_reg;
      stop_cnt_next = stop_cnt_reg;
      start_frame   = 1'b0;
      pop           = 1'b0;
      baud_next     = (state_reg == IDLE || bit_end) ? '0 : baud_reg + 1'b1;
`ifdef UART_TX_PARITY_EN
      par_mode_next = par_mode_reg;
      par_acc_next  = par_acc_reg;
      par_bit       = par_acc_reg ^ tx_reg;
`endif
      case (state_reg)
         IDLE: begin
            if (cfg_en_i && !empty) start_frame = 1'b1;
         end
         START: begin
            if (bit_end) begin
               state_next   = DATA;
               tx_next      = shift_reg[0];
               shift_next   = {1'b0, shift_reg[7:1]};
               bit_cnt_next = '0;
            end
         end
         DATA: begin
            if (bit_end) begin
`ifdef UART_TX_PARITY_EN
               par_acc_next = par_bit;
`endif
               if (bit_cnt_reg == nbits_reg) begin
                  state_next    = STOP;
                  tx_next       = 1'b1;
                  stop_cnt_next = 1'b0;
`ifdef UART_TX_PARITY_EN
                  if (par_mode_reg == 2'b01 || par_mode_reg == 2'b10) begin
                     state_next = PARITY;
                     tx_next    = (par_mode_reg == 2'b10) ? par_bit : ~par_bit;
                  end
`endif
               end else begin
                  bit_cnt_next = bit_cnt_reg + 1'b1;
                  tx_next      = shift_reg[0];
                  shift_next   = {1'b0, shift_reg[7:1]};
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (bit_end) begin
               state_next    = STOP;
               tx_next       = 1'b1;
               stop_cnt_next = 1'b0;
            end
         end
`endif
         STOP: begin
            if (bit_end) begin
               if (two_stop_reg && !stop_cnt_reg) begin
                  stop_cnt_next = 1'b1;
               end else if (cfg_en_i && !empty) begin
                  start_frame = 1'b1;
               end else begin
                  state_next = IDLE;
                  tx_next    = 1'b1;
               end
            end
         end
         default: begin
            state_next = IDLE;
            tx_next    = 1'b1;
         end
      endcase
      // Frame start: pop the head word and freeze the configuration for this frame
      if (start_frame) begin
         pop           = 1'b1;
         state_next    = START;
         tx_next       = 1'b0;
         shift_next    = mem[rd_ptr_reg];
         nbits_next    = {1'b1, cfg_bits_i};
         two_stop_next = cfg_stop_i;
         div_next      = (cfg_div_i == '0) ? DIV_W'(1) : cfg_div_i;
         baud_next     = '0;
`ifdef UART_TX_PARITY_EN
         par_mode_next = cfg_parity_i;
         par_acc_next  = 1'b0;
`endif
      end
      busy_next = (state_next != IDLE);
   end

   // Frame engine registers; reset abandons any frame in flight
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg    <= IDLE;
         busy_reg     <= 1'b0;
         tx_reg       <= 1'b1;
         shift_reg    <= '0;
         nbits_reg    <= 3'd7;
         two_stop_reg <= 1'b0;
         div_reg      <= DIV_W'(1);
         baud_reg     <= '0;
         bit_cnt_reg  <= '0;
         stop_cnt_reg <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_mode_reg <= 2'b00;
         par_acc_reg  <= 1'b0;
`endif
      end else begin
         state_reg    <= state_next;
         busy_reg     <= busy_next;
         tx_reg       <= tx_next;
         shift_reg    <= shift_next;
         nbits_reg    <= nbits_next;
         two_stop_reg <= two_stop_next;
         div_reg      <= div_next;
         baud_reg     <= baud_next;
         bit_cnt_reg  <= bit_cnt_next;
         stop_cnt_reg <= stop_cnt_next;
`ifdef UART_TX_PARITY_EN
         par_mode_reg <= par_mode_next;
         par_acc_reg  <= par_acc_next;
`endif
      end
   end

endmodule
